// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    OR  = 4'd2,
    XOR = 4'd3,
    AND = 4'd4,
    LSR = 4'd5,
    ROR = 4'd6,
    ASL = 4'd7,
    ROL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BCD  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Only ADD and SUB honour decimal mode.
  function automatic logic is_dec_op(input logic [3:0] op);
    return (op == 4'(ADD)) || (op == 4'(SUB));
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between operand muxes, the ALU and writeback.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] AI;
  logic [WIDTH-1:0] BI;
  logic             CI;
  logic             D;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             N;
  logic             V;
  logic             Z;
  logic             CO;
  logic             HC;

  modport master (
    output in_valid, ctrl, AI, BI, CI, D, out_ready,
    input  in_ready, out_valid, out, N, V, Z, CO, HC
  );

  modport slave (
    input  in_valid, ctrl, AI, BI, CI, D, out_ready,
    output in_ready, out_valid, out, N, V, Z, CO, HC
  );
endinterface

// File: rtl/bcd_digit.sv
// One decimal digit of add/subtract; chained LSB-first by the ALU FSM.
module bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       c_out
);

  logic [5:0] raw;
  logic [5:0] adj;

  // Subtraction result is a 6-bit two's complement value; bit 5 flags a borrow.
  always_comb begin
    raw   = '0;
    adj   = '0;
    c_out = 1'b0;
    if (sub) begin
      raw = {2'b00, a} - {2'b00, b} - {5'b0, ~c};
      if (raw[5]) begin
        adj   = raw + 6'd10;
        c_out = 1'b0;
      end else begin
        adj   = raw;
        c_out = 1'b1;
      end
    end else begin
      raw = {2'b00, a} + {2'b00, b} + {5'b0, c};
      if (raw > 6'd9) begin
        adj   = raw + 6'd6;
        c_out = 1'b1;
      end else begin
        adj   = raw;
      end
    end
    digit = adj[3:0];
  end

endmodule

// File: rtl/alu_seq.sv
// Registered 6502-style ALU: single-cycle binary ops, nibble-serial decimal ADD/SUB.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned CW  = $clog2(NIB) + 1;

  alu_state_t       state, state_nxt;
  alu_op_t          op_c;
  logic             accept_c, dec_c, last_c;

  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH:0]   sum_c;
  logic [4:0]       lo_sum_c;
  logic             ovf_c;
  logic [WIDTH-1:0] bin_res_c;
  logic             bin_co_c, bin_v_c, bin_hc_c, bin_def_c;

  logic [WIDTH-1:0] out_q;
  logic             n_q, v_q, z_q, co_q, hc_q;
  logic [WIDTH-1:0] da_q, db_q, res_q, res_nxt_c;
  logic             dc_q, dsub_q, dv_q, dhc_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       dig_c;
  logic             dco_c;

  assign op_c     = alu_op_t'(bus.ctrl);
  assign dec_c    = bus.D & is_dec_op(bus.ctrl);
  assign accept_c = bus.in_valid & bus.in_ready;
  assign last_c   = (cnt_q == CW'(NIB - 1));

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.N         = n_q;
  assign bus.V         = v_q;
  assign bus.Z         = z_q;
  assign bus.CO        = co_q;
  assign bus.HC        = hc_q;

  // Shared adder: SUB is A + ~B + CI, so CI=1 means no borrow.
  assign b_eff_c  = (op_c == SUB) ? ~bus.BI : bus.BI;
  assign sum_c    = {1'b0, bus.AI} + {1'b0, b_eff_c} + (WIDTH+1)'(bus.CI);
  assign lo_sum_c = {1'b0, bus.AI[3:0]} + {1'b0, b_eff_c[3:0]} + 5'(bus.CI);
  assign ovf_c    = (bus.AI[WIDTH-1] == b_eff_c[WIDTH-1]) &
                    (sum_c[WIDTH-1] != bus.AI[WIDTH-1]);

  always_comb begin
    bin_res_c = '0;
    bin_co_c  = 1'b0;
    bin_v_c   = 1'b0;
    bin_hc_c  = 1'b0;
    bin_def_c = 1'b1;
    case (op_c)
      ADD, SUB: begin
        bin_res_c = sum_c[WIDTH-1:0];
        bin_co_c  = sum_c[WIDTH];
        bin_v_c   = ovf_c;
        bin_hc_c  = lo_sum_c[4];
      end
      OR:  begin bin_res_c = bus.AI | bus.BI; bin_co_c = bus.CI; end
      XOR: begin bin_res_c = bus.AI ^ bus.BI; bin_co_c = bus.CI; end
      AND: begin bin_res_c = bus.AI & bus.BI; bin_co_c = bus.CI; end
      LSR: begin bin_res_c = {1'b0, bus.AI[WIDTH-1:1]};   bin_co_c = bus.AI[0]; end
      ROR: begin bin_res_c = {bus.CI, bus.AI[WIDTH-1:1]}; bin_co_c = bus.AI[0]; end
      ASL: begin bin_res_c = {bus.AI[WIDTH-2:0], 1'b0};   bin_co_c = bus.AI[WIDTH-1]; end
      ROL: begin bin_res_c = {bus.AI[WIDTH-2:0], bus.CI}; bin_co_c = bus.AI[WIDTH-1]; end
      default: bin_def_c = 1'b0;
    endcase
  end

  bcd_digit u_digit (
    .a     (da_q[3:0]),
    .b     (db_q[3:0]),
    .c     (dc_q),
    .sub   (dsub_q),
    .digit (dig_c),
    .c_out (dco_c)
  );

  // Digits enter at the top and shift down, so after NIB steps digit 0 sits at the LSB.
  assign res_nxt_c = (res_q >> 4) | (WIDTH'(dig_c) << (WIDTH - 4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept_c)                            state_nxt = dec_c ? BCD : DONE;
        else if ((state == DONE) && bus.out_ready) state_nxt = IDLE;
      end
      BCD:     if (last_c) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      z_q    <= 1'b0;
      co_q   <= 1'b0;
      hc_q   <= 1'b0;
      da_q   <= '0;
      db_q   <= '0;
      res_q  <= '0;
      dc_q   <= 1'b0;
      dsub_q <= 1'b0;
      dv_q   <= 1'b0;
      dhc_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (accept_c) begin
      if (dec_c) begin
        da_q   <= bus.AI;
        db_q   <= bus.BI;
        dc_q   <= bus.CI;
        dsub_q <= (op_c == SUB);
        dv_q   <= bin_v_c;
        res_q  <= '0;
        cnt_q  <= '0;
      end else begin
        out_q <= bin_res_c;
        n_q   <= bin_res_c[WIDTH-1];
        z_q   <= bin_def_c & (bin_res_c == '0);
        co_q  <= bin_co_c;
        v_q   <= bin_v_c;
        hc_q  <= bin_hc_c;
      end
    end else if (state == BCD) begin
      da_q  <= da_q >> 4;
      db_q  <= db_q >> 4;
      dc_q  <= dco_c;
      res_q <= res_nxt_c;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == '0) dhc_q <= dco_c;
      if (last_c) begin
        out_q <= res_nxt_c;
        n_q   <= res_nxt_c[WIDTH-1];
        z_q   <= (res_nxt_c == '0);
        co_q  <= dco_c;
        v_q   <= dv_q;
        hc_q  <= (cnt_q == '0) ? dco_c : dhc_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  alu_seq #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  // Issue one op on the 8-bit DUT; lat = edges from accept (inclusive) to out_valid.
  task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic d, output int lat);
    int w;
    @(negedge clk);
    b8.ctrl = op; b8.AI = a; b8.BI = b; b8.CI = ci; b8.D = d;
    b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    w = 0;
    while (!b8.in_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    b8.in_valid = 1'b0;
    lat = 1;
    while (!b8.out_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic run16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic d, output int lat);
    int w;
    @(negedge clk);
    b16.ctrl = op; b16.AI = a; b16.BI = b; b16.CI = ci; b16.D = d;
    b16.in_valid = 1'b1; b16.out_ready = 1'b0;
    w = 0;
    while (!b16.in_ready && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    b16.in_valid = 1'b0;
    lat = 1;
    while (!b16.out_valid && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic consume8();
    @(negedge clk); b8.out_ready = 1'b1;
    @(negedge clk); b8.out_ready = 1'b0;
  endtask

  task automatic consume16();
    @(negedge clk); b16.out_ready = 1'b1;
    @(negedge clk); b16.out_ready = 1'b0;
  endtask

  // Flags are compared as {N,V,Z,CO,HC}.
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({b8.out_valid, b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC, b8.in_ready} !== {1'b0, 8'h00, 5'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset8 got ov=%b out=%h flags=%b rdy=%b want ov=0 out=00 flags=00000 rdy=1",
               b8.out_valid, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC}, b8.in_ready);
    end
    checks++;
    if ({b16.out_valid, b16.out, b16.N, b16.V, b16.Z, b16.CO, b16.HC, b16.in_ready} !== {1'b0, 16'h0000, 5'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset16 got ov=%b out=%h flags=%b rdy=%b want ov=0 out=0000 flags=00000 rdy=1",
               b16.out_valid, b16.out, {b16.N, b16.V, b16.Z, b16.CO, b16.HC}, b16.in_ready);
    end
  endtask

  task automatic test_bin_add();
    int lat;
    run8(ADD, 8'h50, 8'h50, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_lat got %0d want 1", lat); end
    checks++;
    if ({b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {8'hA0, 5'b11000}) begin
      failures++;
      $display("FAIL add_50_50 got out=%h flags=%b want out=a0 flags=11000", b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
  endtask

  task automatic test_bcd8();
    int lat;
    run8(ADD, 8'h58, 8'h46, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL bcd_add_lat got %0d want 3", lat); end
    checks++;
    if ({b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {8'h05, 5'b01011}) begin
      failures++;
      $display("FAIL bcd_add_58_46 got out=%h flags=%b want out=05 flags=01011", b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
    run8(SUB, 8'h12, 8'h21, 1'b1, 1'b1, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL bcd_sub_lat got %0d want 3", lat); end
    checks++;
    if ({b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {8'h91, 5'b10001}) begin
      failures++;
      $display("FAIL bcd_sub_12_21 got out=%h flags=%b want out=91 flags=10001", b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
  endtask

  task automatic test_bcd16();
    int lat;
    run16(ADD, 16'h9999, 16'h0001, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 5) begin failures++; $display("FAIL bcd16_lat got %0d want 5", lat); end
    checks++;
    if ({b16.out, b16.N, b16.V, b16.Z, b16.CO, b16.HC} !== {16'h0000, 5'b00111}) begin
      failures++;
      $display("FAIL bcd16_9999_1 got out=%h flags=%b want out=0000 flags=00111", b16.out, {b16.N, b16.V, b16.Z, b16.CO, b16.HC});
    end
    consume16();
  endtask

  task automatic test_shift_logic();
    int lat;
    run8(ROR, 8'h01, 8'hFF, 1'b1, 1'b0, lat);
    checks++;
    if ({b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {8'h80, 5'b10010}) begin
      failures++;
      $display("FAIL ror_01 got out=%h flags=%b want out=80 flags=10010", b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
    run8(ASL, 8'h80, 8'h00, 1'b1, 1'b0, lat);
    checks++;
    if ({b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {8'h00, 5'b00110}) begin
      failures++;
      $display("FAIL asl_80 got out=%h flags=%b want out=00 flags=00110", b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
    run8(XOR, 8'hF0, 8'h3C, 1'b1, 1'b1, lat);
    checks++;
    if ({lat[3:0], b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {4'd1, 8'hCC, 5'b10010}) begin
      failures++;
      $display("FAIL xor_f0_3c got lat=%0d out=%h flags=%b want lat=1 out=cc flags=10010", lat, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
    run8(4'hF, 8'h00, 8'h00, 1'b1, 1'b0, lat);
    checks++;
    if ({lat[3:0], b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {4'd1, 8'h00, 5'b00000}) begin
      failures++;
      $display("FAIL undef_op got lat=%0d out=%h flags=%b want lat=1 out=00 flags=00000", lat, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
  endtask

  task automatic test_back_to_back();
    int lat;
    run8(AND, 8'hF0, 8'h3C, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({b8.out_valid, b8.in_ready, b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {2'b10, 8'h30, 5'b00000}) begin
        failures++;
        $display("FAIL hold_%0d got ov=%b rdy=%b out=%h flags=%b want ov=1 rdy=0 out=30 flags=00000",
                 i, b8.out_valid, b8.in_ready, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
      end
    end
    @(negedge clk);
    b8.ctrl = OR; b8.AI = 8'h0F; b8.BI = 8'hA0; b8.CI = 1'b1; b8.D = 1'b0;
    b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    #1;
    checks++;
    if (b8.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got %b want 1", b8.in_ready); end
    @(negedge clk);
    b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    checks++;
    if ({b8.out_valid, b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {1'b1, 8'hAF, 5'b10010}) begin
      failures++;
      $display("FAIL b2b_or got ov=%b out=%h flags=%b want ov=1 out=af flags=10010",
               b8.out_valid, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
  endtask

  task automatic test_reset_mid_bcd();
    int lat;
    @(negedge clk);
    b8.ctrl = ADD; b8.AI = 8'h58; b8.BI = 8'h46; b8.CI = 1'b1; b8.D = 1'b1;
    b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b8.out_valid, b8.in_ready, b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {2'b01, 8'h00, 5'b00000}) begin
      failures++;
      $display("FAIL rst_mid_bcd got ov=%b rdy=%b out=%h flags=%b want ov=0 rdy=1 out=00 flags=00000",
               b8.out_valid, b8.in_ready, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run8(ADD, 8'h01, 8'h02, 1'b0, 1'b0, lat);
    checks++;
    if ({lat[3:0], b8.out, b8.N, b8.V, b8.Z, b8.CO, b8.HC} !== {4'd1, 8'h03, 5'b00000}) begin
      failures++;
      $display("FAIL post_rst_add got lat=%0d out=%h flags=%b want lat=1 out=03 flags=00000",
               lat, b8.out, {b8.N, b8.V, b8.Z, b8.CO, b8.HC});
    end
    consume8();
  endtask

  initial begin
    rst_n = 1'b0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.ctrl = '0; b8.AI = '0; b8.BI = '0; b8.CI = 1'b0; b8.D = 1'b0;
    b16.in_valid = 1'b0; b16.out_ready = 1'b0; b16.ctrl = '0; b16.AI = '0; b16.BI = '0; b16.CI = 1'b0; b16.D = 1'b0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_bin_add();
    test_bcd8();
    test_bcd16();
    test_shift_logic();
    test_back_to_back();
    test_reset_mid_bcd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational 6502 ALU.
- Binary ops: ADD with carry, SUB with borrow (6502 convention), OR, XOR, AND, LSR, ROR, ASL, ROL. Width is WIDTH bits, a multiple of 4.
- Decimal (BCD) ADD and SUB are fully implemented. They run nibble-serially over multiple cycles.
- Sits between register-file operand muxes and the status-register/accumulator writeback, behind a valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; multiple of 4, at least 4.
- NIB, WIDTH/4, derived (localparam): digit count for decimal ops.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept operation.
- ctrl  in  4  opcode (alu_pkg::alu_op_t).
- AI  in  WIDTH  operand A.
- BI  in  WIDTH  operand B (ignored by shifts).
- CI  in  1  carry in; for SUB, 1 = no borrow.
- D  in  1  decimal mode; only affects ADD/SUB.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- N  out  1  out[WIDTH-1].
- V  out  1  signed overflow.
- Z  out  1  out == 0.
- CO  out  1  carry out (SUB: 1 = no borrow; shifts: bit shifted out).
- HC  out  1  carry/no-borrow out of nibble 0.

Behaviour:
- Reset: FSM goes to IDLE. out, N, V, Z, CO, HC and out_valid are all 0; in_ready is 1 once the FSM is in IDLE.
- FSM states are IDLE, BCD, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - out_valid = (state==DONE).
- Accept: an operation is accepted on a clock edge where in_valid & in_ready. Operands, ctrl, CI and D are captured.
- Binary path (D=0, or any op other than ADD/SUB): the result is computed and registered on the accept edge; the FSM goes to DONE. out_valid rises 1 cycle after acceptance.
- Decimal path (D=1 with ADD/SUB): the FSM goes to BCD. One digit is processed per cycle, LSB digit first, with the carry chained. After NIB cycles the FSM goes to DONE, so out_valid rises NIB+1 cycles after acceptance (3 for WIDTH=8).
- Digit add: s = a+b+c (5 bits). If s>9, then s += 6 and c_out = 1, else c_out = 0. The digit is s[3:0].
- Digit sub: d = a-b-(~c). If d<0, then d += 10 and c_out = 0, else c_out = 1. The digit is d[3:0].
- Non-BCD input digits are not errors; the result is exactly what the digit rules above produce.
- V in decimal mode equals V of the equivalent binary ADD/SUB on the same operands.
- Binary arithmetic and flags:
  - ADD: {CO,out} = A + B + CI. V = (A[msb]==B[msb]) & (out[msb]!=A[msb]).
  - SUB: {CO,out} = A + ~B + CI. V is computed the same way, using ~B in place of B.
  - HC is the carry out of bit 3 of the same sum.
  - Logic ops: CO = CI, V = 0, HC = 0.
  - LSR shifts in 0; ROR shifts in CI; ASL shifts in 0; ROL shifts in CI. CO is the bit shifted out, V = 0, HC = 0.
- Hold: in DONE, out and all flags stay stable until out_ready.
  - DONE & out_ready & in_valid: the next operation is accepted the same edge (back-to-back, no bubble).
  - DONE & out_ready & ~in_valid: return to IDLE.
- Undefined ctrl codes produce out=0, flags 0, 1-cycle latency.
- Reset asserted mid-BCD or in DONE aborts the operation immediately. No output is produced.
- Inputs are ignored while in BCD (in_ready=0).

Decomposition:
- Package alu_pkg contains:
  - alu_op_t enum: ADD=0, SUB=1, OR=2, XOR=3, AND=4, LSR=5, ROR=6, ASL=7, ROL=8.
  - alu_state_t enum: IDLE, BCD, DONE.
- Sub-module bcd_digit: combinational one-digit add/sub with inputs a, b, c, sub and outputs digit, c_out. The FSM instantiates it once and iterates it per cycle.

Test Plan:
- WIDTH=8, D=0, ADD 0x50+0x50, CI=0 -> out=0xA0, N=1, V=1, Z=0, CO=0, HC=0; out_valid 1 cycle after accept.
- WIDTH=8, D=1, ADD 0x58+0x46, CI=1 -> out=0x05, CO=1, HC=1; out_valid 3 cycles after accept. SUB 0x12-0x21, CI=1 -> out=0x91, CO=0, N=1.
- WIDTH=16, D=1, ADD 0x9999+0x0001, CI=0 -> out=0x0000, Z=1, CO=1; latency 5 cycles.
- WIDTH=8, ROR 0x01, CI=1 -> out=0x80, CO=1, N=1, V=0. ASL 0x80, CI=1 -> out=0x00, CO=1, Z=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out and flags stable, in_ready=0.
  - Then assert out_ready together with a new in_valid -> the new op is accepted that edge, and the next result appears 1 cycle later.
- Drop rst_n in the 2nd BCD cycle -> next edge-free check: out_valid=0, out=0, flags 0; after release in_ready=1 and a fresh op completes correctly.
